// File: rtl/dm_ctrl.sv
// Data-memory responder for the DM stage: serves loads/stores with a fixed
// number of wait states and holds the pipeline via stall_DM until DONE.
module dm_ctrl #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] OOR_DATA    = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_re_EX_DM,
  input  logic        dm_we_EX_DM,
  input  logic [15:0] dm_addr_EX_DM,
  input  logic [15:0] dm_wrt_data_EX_DM,
  output logic [15:0] dm_rd_data_EX_DM,
  output logic        stall_DM,
  output logic        err_DM
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [15:0]   r_rdData;
  logic          r_err;
  logic [15:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_inRange;
  logic          w_enterDone;
  logic [15:0]   w_upper;
  logic [AW-1:0] w_idx;

  assign w_req     = dm_re_EX_DM | dm_we_EX_DM;
  assign w_upper   = dm_addr_EX_DM >> AW;
  assign w_inRange = (w_upper == 16'd0);
  assign w_idx     = dm_addr_EX_DM[AW-1:0];

  // The access happens on the edge that moves the FSM into DONE.
  assign w_enterDone = ((r_state == IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                       ((r_state == BUSY) && w_req && (r_cnt == 4'd0));

  assign stall_DM = rst_n & (((r_state == IDLE) & w_req) | (r_state == BUSY));

  assign dm_rd_data_EX_DM = r_rdData;
  assign err_DM           = r_err;

  // Array writes share this block so a request held through reset can never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rdData <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_enterDone) begin
        r_err <= ~w_inRange | (dm_re_EX_DM & dm_we_EX_DM);
        if (dm_re_EX_DM)
          r_rdData <= w_inRange ? r_mem[w_idx] : OOR_DATA;
        else if (dm_we_EX_DM && w_inRange)
          r_mem[w_idx] <= dm_wrt_data_EX_DM;
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (WAIT_CYCLES == 0) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (!w_req)
            r_state <= IDLE;
          else if (r_cnt == 4'd0)
            r_state <= DONE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: one instance with two wait states (A) and one
// with none (B); expected completions are queued at issue and popped at DONE.
module tb_dm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        reA, weA, reB, weB;
  logic [15:0] addrA, wdA, addrB, wdB;
  logic [15:0] rdA, rdB;
  logic        stallA, stallB, errA, errB;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] rd;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] lastRd[2];

  dm_ctrl #(.DEPTH(1024), .WAIT_CYCLES(2), .OOR_DATA(16'hDEAD)) u_dutA (
    .clk(clk), .rst_n(rst_n),
    .dm_re_EX_DM(reA), .dm_we_EX_DM(weA),
    .dm_addr_EX_DM(addrA), .dm_wrt_data_EX_DM(wdA),
    .dm_rd_data_EX_DM(rdA), .stall_DM(stallA), .err_DM(errA)
  );

  dm_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0), .OOR_DATA(16'hDEAD)) u_dutB (
    .clk(clk), .rst_n(rst_n),
    .dm_re_EX_DM(reB), .dm_we_EX_DM(weB),
    .dm_addr_EX_DM(addrB), .dm_wrt_data_EX_DM(wdB),
    .dm_rd_data_EX_DM(rdB), .stall_DM(stallB), .err_DM(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic stallOf(input int u);
    return (u == 0) ? stallA : stallB;
  endfunction

  function automatic logic errOf(input int u);
    return (u == 0) ? errA : errB;
  endfunction

  function automatic logic [15:0] rdOf(input int u);
    return (u == 0) ? rdA : rdB;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic re, input logic we,
                       input logic [15:0] addr, input logic [15:0] wd);
    if (u == 0) begin
      reA = re; weA = we; addrA = addr; wdA = wd;
    end else begin
      reB = re; weB = we; addrB = addr; wdB = wd;
    end
  endtask

  // Issue one access at posedge+1, follow it to DONE, compare against the queue.
  task automatic applyStimulus(input int u, input logic re, input logic we,
                               input logic [15:0] addr, input logic [15:0] wd,
                               input logic [15:0] expRd, input logic expErr,
                               input string tag);
    exp_t item;
    int   stalls;
    bit   done;
    item.rd     = re ? expRd : lastRd[u];
    item.err    = expErr;
    item.stalls = (u == 0) ? 3 : 1;
    sb.push_back(item);
    drive(u, re, we, addr, wd);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stallOf(u)) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s_timeout observed=stalled expected=done", tag);
    end
    item = sb.pop_front();
    check({tag, "_stalls"}, 32'(stalls), 32'(item.stalls));
    check({tag, "_rd"}, 32'(rdOf(u)), 32'(item.rd));
    check({tag, "_err"}, 32'(errOf(u)), 32'(item.err));
    lastRd[u] = item.rd;
    @(posedge clk);
    #1;
    drive(u, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic checkOutput(input int u, input logic expStall, input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 32'(stallOf(u)), 32'(expStall));
    check({tag, "_errIdle"}, 32'(errOf(u)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    lastRd[0] = 16'd0;
    lastRd[1] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rstA_stall", 32'(stallA), 32'd0);
    check("rstA_rd", 32'(rdA), 32'd0);
    check("rstA_err", 32'(errA), 32'd0);
    check("rstB_stall", 32'(stallB), 32'd0);
    check("rstB_rd", 32'(rdB), 32'd0);
    check("rstB_err", 32'(errB), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b0, 1'b1, 16'd5, 16'h1234, 16'h0000, 1'b0, "A_wr5");
    applyStimulus(0, 1'b1, 1'b0, 16'd5, 16'h0000, 16'h1234, 1'b0, "A_rd5");

    applyStimulus(1, 1'b0, 1'b1, 16'd5, 16'h1111, 16'h0000, 1'b0, "B_wr5");
    applyStimulus(1, 1'b0, 1'b1, 16'd6, 16'h2222, 16'h0000, 1'b0, "B_wr6");
    applyStimulus(1, 1'b1, 1'b0, 16'd5, 16'h0000, 16'h1111, 1'b0, "B_rd5");
    applyStimulus(1, 1'b1, 1'b0, 16'd6, 16'h0000, 16'h2222, 1'b0, "B_rd6");
    checkOutput(1, 1'b0, "B_afterB2B");
    checkOutput(1, 1'b0, "B_afterB2B_2");

    applyStimulus(0, 1'b0, 1'b1, 16'd0, 16'h0F0F, 16'h0000, 1'b0, "A_wr0");
    applyStimulus(0, 1'b0, 1'b1, 16'h0400, 16'hBEEF, 16'h0000, 1'b1, "A_wrOor");
    applyStimulus(0, 1'b1, 1'b0, 16'd0, 16'h0000, 16'h0F0F, 1'b0, "A_rd0");
    applyStimulus(0, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'hDEAD, 1'b1, "A_rdOor");
    checkOutput(0, 1'b0, "A_errPulse");
    applyStimulus(0, 1'b0, 1'b1, 16'd7, 16'h00AA, 16'h0000, 1'b0, "A_wr7");
    applyStimulus(0, 1'b1, 1'b1, 16'd7, 16'h5555, 16'h00AA, 1'b1, "A_rdwr7");
    applyStimulus(0, 1'b1, 1'b0, 16'd7, 16'h0000, 16'h00AA, 1'b0, "A_rd7");

    applyStimulus(0, 1'b0, 1'b1, 16'd9, 16'h0909, 16'h0000, 1'b0, "A_wr9");
    // Flush: drop the request while the FSM sits in BUSY.
    drive(0, 1'b0, 1'b1, 16'd9, 16'h7777);
    @(negedge clk);
    check("flush_stallIdle", 32'(stallA), 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    check("flush_stallBusy", 32'(stallA), 32'd1);
    @(posedge clk);
    #1;
    checkOutput(0, 1'b0, "flush_idle");
    check("flush_rdHeld", 32'(rdA), 32'(lastRd[0]));
    applyStimulus(0, 1'b1, 1'b0, 16'd9, 16'h0000, 16'h0909, 1'b0, "A_rd9flush");

    // Reset while a write to addr 9 is in BUSY, request still held.
    drive(0, 1'b0, 1'b1, 16'd9, 16'hAAAA);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(stallA), 32'd0);
    check("midrst_rdA", 32'(rdA), 32'd0);
    check("midrst_rdB", 32'(rdB), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_stallHeld", 32'(stallA), 32'd0);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    lastRd[0] = 16'd0;
    lastRd[1] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 1'b0, 16'd9, 16'h0000, 16'h0909, 1'b0, "A_rd9rst");
    applyStimulus(1, 1'b1, 1'b0, 16'd6, 16'h0000, 16'h2222, 1'b0, "B_rd6rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
